// File: rtl/classificador_notas_param.sv
// Note-sequence classifier: samples the note bus on rising edges of ok and walks a
// Moore FSM over up to four notes plus a pause, showing the result on a 7-seg digit.
module classificador_notas_param #(
  parameter int NOTE_W          = 4,
  parameter int TIMEOUT_CYC     = 1000,
  parameter bit DISP_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ok,
  input  logic [NOTE_W-1:0] nota,
  output logic              fim,
  output logic [1:0]        tipo,
  output logic              erro,
  output logic [2:0]        contagem,
  output logic [6:0]        display
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYC > 0);

  typedef enum logic [3:0] {
    INICIAL, NOTA1, NOTA2, N3_LA, N3_SI, N4_DO, N4_RE, N4_SI, ADJ, COMP, ADV, ERRO
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          ok_q;

  logic       hi_ok;
  logic [3:0] lo;
  logic       is_pausa, is_la, is_si, is_do, is_re;
  logic       ev, counting, tmo, step, p;
  logic       n_ok, n_la, n_si, n_do, n_re;
  logic [6:0] seg;

  // Upper bits exist only when the bus is wider than a nibble.
  if (NOTE_W > 4) begin : g_hi
    assign hi_ok = ~|nota[NOTE_W-1:4];
  end else begin : g_nohi
    assign hi_ok = 1'b1;
  end

  assign lo       = nota[3:0];
  assign is_pausa = hi_ok & ((lo == 4'd0) | (lo == 4'd8));
  assign is_la    = hi_ok & (lo == 4'd6);
  assign is_si    = hi_ok & (lo == 4'd15);
  assign is_do    = hi_ok & (lo == 4'd9);
  assign is_re    = hi_ok & (lo == 4'd2);

  assign ev       = ok & ~ok_q;
  assign counting = state_q inside {NOTA1, NOTA2, N3_LA, N3_SI, N4_DO, N4_RE, N4_SI};
  assign tmo      = TO_EN && counting && (tmr_q == TMAX) && !ev;
  assign step     = ev | tmo;
  // An expired timer behaves exactly like a pause note.
  assign p        = tmo | (ev & is_pausa);
  assign n_ok     = ev & hi_ok & ~is_pausa;
  assign n_la     = ev & is_la;
  assign n_si     = ev & is_si;
  assign n_do     = ev & is_do;
  assign n_re     = ev & is_re;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INICIAL: if (ev) begin
        if (n_ok) begin state_d = NOTA1; cnt_d = cnt_q + 3'd1; end
        else state_d = ERRO;
      end
      NOTA1: if (step) begin
        if (n_ok) begin state_d = NOTA2; cnt_d = cnt_q + 3'd1; end
        else state_d = ERRO;
      end
      NOTA2: if (step) begin
        if (n_la)      begin state_d = N3_LA; cnt_d = cnt_q + 3'd1; end
        else if (n_si) begin state_d = N3_SI; cnt_d = cnt_q + 3'd1; end
        else state_d = ERRO;
      end
      N3_LA: if (step) begin
        if (p)         state_d = ADJ;
        else if (n_do) begin state_d = N4_DO; cnt_d = cnt_q + 3'd1; end
        else if (n_si) begin state_d = N4_SI; cnt_d = cnt_q + 3'd1; end
        else state_d = ERRO;
      end
      N3_SI: if (step) begin
        if (p)         state_d = ADJ;
        else if (n_re) begin state_d = N4_RE; cnt_d = cnt_q + 3'd1; end
        else state_d = ERRO;
      end
      N4_DO, N4_RE: if (step) state_d = p ? COMP : ERRO;
      N4_SI:        if (step) state_d = p ? ADV : ERRO;
      ADJ, COMP, ADV, ERRO: if (ev) begin state_d = INICIAL; cnt_d = 3'd0; end
      default: begin state_d = INICIAL; cnt_d = 3'd0; end
    endcase
  end

  assign tmr_d = (ev || (state_d != state_q) || !counting) ? '0 : tmr_q + TW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INICIAL;
      cnt_q   <= 3'd0;
      tmr_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      ok_q    <= ok;
    end
  end

  always_comb begin
    fim  = state_q inside {ADJ, COMP, ADV, ERRO};
    erro = (state_q == ERRO);
    tipo = 2'b00;
    case (state_q)
      ADJ:     tipo = 2'b01;
      COMP:    tipo = 2'b10;
      ADV:     tipo = 2'b11;
      default: tipo = 2'b00;
    endcase
    seg = 7'b0000000;
    case (state_q)
      ADJ:  seg = 7'b1110111;
      COMP: seg = 7'b0111001;
      ADV:  seg = 7'b1011110;
      ERRO: seg = 7'b1111001;
      default: begin
        case (cnt_q)
          3'd0:    seg = 7'b0111111;
          3'd1:    seg = 7'b0000110;
          3'd2:    seg = 7'b1011011;
          3'd3:    seg = 7'b1001111;
          3'd4:    seg = 7'b1100110;
          default: seg = 7'b0000000;
        endcase
      end
    endcase
  end

  assign contagem = cnt_q;
  assign display  = DISP_ACTIVE_LOW ? ~seg : seg;

endmodule

// File: tb/tb_classificador_notas_param.sv
// Directed bench for the note classifier: 5-bit notes, 8-cycle timeout, active-low display.
module tb_classificador_notas_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       ok;
  logic [4:0] nota;
  logic       fim;
  logic [1:0] tipo;
  logic       erro;
  logic [2:0] contagem;
  logic [6:0] display;

  int total  = 0;
  int passed = 0;

  // Active-low glyphs, hand-inverted from the gfedcba patterns.
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GD = 7'b0100001;
  localparam logic [6:0] GE = 7'b0000110;

  classificador_notas_param #(
    .NOTE_W(5), .TIMEOUT_CYC(8), .DISP_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .ok(ok), .nota(nota),
    .fim(fim), .tipo(tipo), .erro(erro), .contagem(contagem), .display(display)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] o(input logic f, input logic [1:0] t, input logic e,
                                    input logic [2:0] c, input logic [6:0] d);
    return {f, t, e, c, d};
  endfunction

  task automatic chk(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    obs = {fim, tipo, erro, contagem, display};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed={fim,tipo,erro,cnt,disp}=%b required=%b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One ok pulse, high 3 cycles; nota is scrambled after the event cycle.
  task automatic press(input logic [4:0] n);
    nota = n;
    ok   = 1'b1;
    tick();
    nota = 5'h1F;
    tick();
    tick();
    ok = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; ok = 1'b0; nota = 5'd0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("reset", o(0, 2'b00, 0, 3'd0, G0));

    press(5'd3); chk("adj_n1", o(0, 2'b00, 0, 3'd1, G1));
    press(5'd5); chk("adj_n2", o(0, 2'b00, 0, 3'd2, G2));
    press(5'd6); chk("adj_n3", o(0, 2'b00, 0, 3'd3, G3));
    press(5'd0); chk("adj_end", o(1, 2'b01, 0, 3'd3, GA));
    press(5'd7); chk("restart_adj", o(0, 2'b00, 0, 3'd0, G0));

    press(5'd1); press(5'd1); press(5'd6); press(5'd9); press(5'd8);
    chk("comp_do", o(1, 2'b10, 0, 3'd4, GC));
    press(5'd3); chk("restart_comp", o(0, 2'b00, 0, 3'd0, G0));

    press(5'd4); press(5'd4); press(5'd15); press(5'd2); press(5'd0);
    chk("comp_re", o(1, 2'b10, 0, 3'd4, GC));
    nota = 5'd1; ok = 1'b1;
    repeat (20) tick();
    ok = 1'b0;
    tick();
    chk("hold_ok", o(0, 2'b00, 0, 3'd0, G0));

    press(5'd7); press(5'd7); press(5'd6); press(5'd15); press(5'd0);
    chk("adv", o(1, 2'b11, 0, 3'd4, GD));
    press(5'd0); chk("restart_adv", o(0, 2'b00, 0, 3'd0, G0));

    press(5'd1); press(5'd1); press(5'd3);
    chk("erro_n3", o(1, 2'b00, 1, 3'd2, GE));
    press(5'd0); chk("restart_erro", o(0, 2'b00, 0, 3'd0, G0));

    press(5'd1); press(5'd1); press(5'b10110);
    chk("erro_hi", o(1, 2'b00, 1, 3'd2, GE));
    press(5'd0);

    press(5'd2); press(5'd2);
    nota = 5'd6; ok = 1'b1;
    tick();
    ok = 1'b0;
    repeat (7) tick();
    chk("to_adj_pre", o(0, 2'b00, 0, 3'd3, G3));
    tick();
    chk("to_adj", o(1, 2'b01, 0, 3'd3, GA));
    press(5'd0);

    nota = 5'd2; ok = 1'b1;
    tick();
    ok = 1'b0;
    repeat (7) tick();
    chk("to_n1_pre", o(0, 2'b00, 0, 3'd1, G1));
    tick();
    chk("to_n1_erro", o(1, 2'b00, 1, 3'd1, GE));
    press(5'd0);

    press(5'd2);
    nota = 5'd2; ok = 1'b1;
    tick();
    ok = 1'b0;
    repeat (7) tick();
    nota = 5'd6; ok = 1'b1;
    tick();
    chk("ev_over_to", o(0, 2'b00, 0, 3'd3, G3));
    ok = 1'b0;
    tick();
    press(5'd0);
    chk("ev_over_to_end", o(1, 2'b01, 0, 3'd3, GA));
    press(5'd0);

    press(5'd7); press(5'd7); press(5'd6); press(5'd15);
    chk("n4_si", o(0, 2'b00, 0, 3'd4, G4));
    reset = 1'b1;
    #2;
    chk("async_reset", o(0, 2'b00, 0, 3'd0, G0));
    #1;
    reset = 1'b0;
    tick();
    press(5'd1); press(5'd1); press(5'd6); press(5'd0);
    chk("post_reset_adj", o(1, 2'b01, 0, 3'd3, GA));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
